bus_arbiter_2m: RTL and testbench
=================================

// Module: bus_arbiter_2m
// PURPOSE
//  Two-master to one-slave arbiter for the 32-bit processor bus. Shares the memory/peripheral bus
//  (addr/read/write/byteenable/waitrequest/response) between the RISC-V core wrapper (M0) and a
//  second master (M1, DMA / debug loader). Holds each grant for exactly one transfer, with
//  round-robin fairness. A watchdog terminates transfers the slave never acknowledges.
// PARAMETERS
//  ADDR_W          32    address width, all ports
//  DATA_W          32    data width; byteenable width is DATA_W/8
//  ROUND_ROBIN     1     1 = alternate on contention; 0 = M0 always wins contention
//  TIMEOUT_CYCLES  1024  cycles of slave waitrequest before forced error completion; 0 = disabled
// PORTS
//  clk               in   1         system clock
//  rst               in   1         synchronous, active-high reset
//  m0_addr/m1_addr   in   ADDR_W    master address
//  mX_read, mX_write in   1         command strobes, Avalon semantics; never both high
//  mX_writedata      in   DATA_W    write data
//  mX_byteenable     in   DATA_W/8  byte lanes
//  mX_readdata       out  DATA_W    slave readdata when granted, else 0
//  mX_response       out  2         00 OKAY, 10 SLVERR (timeout), passthrough when granted, else 00
//  mX_waitrequest    out  1         low only in the completion cycle of that master's transfer
//  s_addr            out  ADDR_W    muxed address to slave
//  s_read, s_write   out  1         muxed strobes, 0 when no grant
//  s_writedata       out  DATA_W    muxed write data
//  s_byteenable      out  DATA_W/8  muxed byte lanes
//  s_readdata        in   DATA_W    slave read data
//  s_response        in   2         slave response
//  s_waitrequest     in   1         slave stall
//  grant             out  2         one-hot current owner {M1,M0}; 00 = idle
//  timeout_pulse     out  1         1-cycle pulse when the watchdog fires
// BEHAVIOUR
//  - FSM states: IDLE, GNT_M0, GNT_M1. The grant is registered. Slave-side outputs and master
//    readdata/response/waitrequest are combinational muxes of the registered grant.
//  - Reset: state=IDLE, last=M1 (M0 wins the first contention), wdog=0. Outputs are then
//    grant=00, s_read=s_write=0, s_addr/s_writedata/s_byteenable=0, mX_waitrequest=1,
//    mX_readdata=0, mX_response=00, timeout_pulse=0. Reset mid-transfer drops it silently.
//  - Request: reqX = mX_read|mX_write.
//  - IDLE -> GNT_X on the next edge if reqX is high. Arbitration adds 1 cycle of latency.
//  - Contention (both requesting): ROUND_ROBIN=1 picks the master != last; ROUND_ROBIN=0 picks M0.
//  - In GNT_X: slave inputs are driven from master X. Completion = reqX && !s_waitrequest.
//    On completion: mX_waitrequest=0; mX_readdata/response = s_readdata/s_response; last <= X.
//  - After completion the arbiter re-arbitrates in the same edge. Next state = GNT_Y per the
//    arbitration rule using the current-cycle reqs, or IDLE if neither requests. This gives
//    back-to-back transfers with no dead cycle.
//  - A strobe high in the cycle after completion is a new command.
//  - If reqX drops while granted (protocol violation), the FSM returns to IDLE with no completion.
//  - Non-granted master: waitrequest=1, readdata=0, response=00; its commands stay pending.
//  - Watchdog: wdog counts cycles in GNT_X with s_waitrequest=1 and clears on every state change.
//    If wdog == TIMEOUT_CYCLES-1 and s_waitrequest is still 1, that cycle is a forced completion:
//    mX_waitrequest=0, mX_response=10, mX_readdata=0, timeout_pulse=1. Re-arbitration then
//    proceeds as for a normal completion.
//  - wdog width = $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
//  - Slave completion and the timeout in the same cycle: normal completion wins, no pulse.
//  - TIMEOUT_CYCLES=0 removes the watchdog; timeout_pulse is tied to 0.
// STRUCTURE
//  - bus_arb_pkg holds the state encoding (IDLE/GNT_M0/GNT_M1) and response constants
//    RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
//  - Sub-module rr_pick2: combinational (req0, req1, last, ROUND_ROBIN) -> one-hot pick.
//    It is reused by the IDLE and completion transitions.
//  - Top level: FSM, watchdog counter and output muxes.
// TESTING
//  1. After reset, M0 reads 0x0000_0010 with slave waitrequest low at the first grant cycle:
//     grant=01 one cycle later, m0_waitrequest low for exactly 1 cycle, m0_readdata = s_readdata.
//  2. M0 and M1 write in the same cycle, repeatedly, slave zero-wait: grants alternate
//     01,10,01,... with no IDLE cycle between them. With ROUND_ROBIN=0, M0 is always granted first.
//  3. M1 write, slave stalls 3 cycles: s_write, s_addr, s_writedata and s_byteenable=4'b0101 are
//     stable for 4 cycles. m1_waitrequest=0 on the 4th. m0_waitrequest stays 1 throughout.
//  4. TIMEOUT_CYCLES=8, slave waitrequest stuck high: completion after 8 granted cycles with
//     m0_response=10, readdata=0, a 1-cycle timeout_pulse. Returns to IDLE or serves M1.
//  5. Assert rst mid-transfer, in GNT_M1 with slave stalled: next cycle grant=00, s_read=0,
//     waitrequests=1. The next contention is granted to M0.
//  6. Slave acknowledges in the exact wdog == TIMEOUT_CYCLES-1 cycle: response=OKAY, no pulse.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared constants for the two-master bus arbiter: FSM state encoding,
// bus response codes and the mapping from a one-hot arbitration pick to the
// next grant state.
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    // State encoding is one-hot per owner so the grant output is the state itself.
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Identity of the master that completed most recently.
    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    function automatic logic [1:0] state_from_pick(input logic [1:0] pick);
        case (pick)
            2'b01:   return GNT_M0;
            2'b10:   return GNT_M1;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter_2m_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m_if
// One Avalon-style memory-mapped port of the processor bus.
//   addr, read, write, writedata, byteenable : command, driven by the master
//   readdata, response, waitrequest          : reply, driven by the slave
// Modport master is the side that issues commands; modport slave answers them.
// -----------------------------------------------------------------------------
interface bus_arbiter_2m_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   addr;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic [1:0]          response;
    logic                waitrequest;

    modport master (
        output addr, read, write, writedata, byteenable,
        input  readdata, response, waitrequest
    );

    modport slave (
        input  addr, read, write, writedata, byteenable,
        output readdata, response, waitrequest
    );
endinterface

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way arbitration decision.
//   req0, req1 : pending requests from M0 / M1
//   last       : master that completed most recently (0 = M0, 1 = M1)
//   pick       : one-hot winner {M1,M0}; 00 when nobody requests
// With ROUND_ROBIN != 0 contention goes to the master that was not last;
// otherwise M0 always wins contention.
// -----------------------------------------------------------------------------
module rr_pick2 #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] pick
);
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else can infer a latch.
    always_comb begin
        pick = 2'b00;
        if (req0 && req1) begin
            pick = (ROUND_ROBIN != 0 && last == 1'b0) ? 2'b10 : 2'b01;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end
endmodule

// File: rtl/bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2m
// Shares one slave port of the 32-bit processor bus between M0 (core wrapper)
// and M1 (DMA / debug loader). A grant covers exactly one transfer; the next
// owner is chosen in the completion cycle so transfers run back to back.
// A watchdog forces an SLVERR completion when the slave stalls too long.
//   clk, rst      : clock, synchronous active-high reset
//   m0, m1        : master-facing ports (arbiter is their slave)
//   s             : slave-facing port (arbiter is its master)
//   grant         : one-hot current owner {M1,M0}, 00 = idle
//   timeout_pulse : one-cycle pulse when the watchdog terminates a transfer
// -----------------------------------------------------------------------------
module bus_arbiter_2m
    import bus_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    bus_arbiter_2m_if.slave         m0,
    bus_arbiter_2m_if.slave         m1,
    bus_arbiter_2m_if.master        s,
    output logic [1:0]              grant,
    output logic                    timeout_pulse
);
    localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0] state, state_next;
    logic       last;
    logic       req0, req1;
    logic       owner_req;
    logic       timeout_hit;
    logic       done;
    logic       last_in;
    logic [1:0] pick;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    assign owner_req = (state == GNT_M0 && req0) || (state == GNT_M1 && req1);
    assign done      = owner_req && (!s.waitrequest || timeout_hit);

    // On completion the finishing master becomes "last" in the same edge, so the
    // pick must already see it as last or contention would grant it twice.
    assign last_in = (state == IDLE) ? last : (state == GNT_M1);

    rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_in),
        .pick (pick)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = state_from_pick(pick);
            GNT_M0, GNT_M1: begin
                if (done)            state_next = state_from_pick(pick);
                else if (!owner_req) state_next = IDLE;   // strobe withdrawn: drop silently
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= LAST_M1;
        end else begin
            state <= state_next;
            if (done) last <= (state == GNT_M1) ? LAST_M1 : LAST_M0;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
            localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
            logic [WDOG_W-1:0] wdog;

            assign timeout_hit = owner_req && s.waitrequest && (wdog == WDOG_LAST);

            // A re-grant to the same master is a new transfer, so completion
            // clears the count as well as a state change does.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wdog <= '0;
                end else if (state == IDLE || done || state_next != state) begin
                    wdog <= '0;
                end else if (s.waitrequest && wdog != WDOG_MAX) begin
                    wdog <= wdog + 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign grant         = state;
    assign timeout_pulse = timeout_hit;

    always_comb begin
        s.addr         = {ADDR_W{1'b0}};
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.writedata    = {DATA_W{1'b0}};
        s.byteenable   = {(DATA_W/8){1'b0}};
        m0.readdata    = {DATA_W{1'b0}};
        m0.response    = RESP_OKAY;
        m0.waitrequest = 1'b1;
        m1.readdata    = {DATA_W{1'b0}};
        m1.response    = RESP_OKAY;
        m1.waitrequest = 1'b1;
        case (state)
            GNT_M0: begin
                s.addr         = m0.addr;
                s.read         = m0.read;
                s.write        = m0.write;
                s.writedata    = m0.writedata;
                s.byteenable   = m0.byteenable;
                m0.readdata    = timeout_hit ? {DATA_W{1'b0}} : s.readdata;
                m0.response    = timeout_hit ? RESP_SLVERR : s.response;
                m0.waitrequest = !done;
            end
            GNT_M1: begin
                s.addr         = m1.addr;
                s.read         = m1.read;
                s.write        = m1.write;
                s.writedata    = m1.writedata;
                s.byteenable   = m1.byteenable;
                m1.readdata    = timeout_hit ? {DATA_W{1'b0}} : s.readdata;
                m1.response    = timeout_hit ? RESP_SLVERR : s.response;
                m1.waitrequest = !done;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2m
// Directed bench for bus_arbiter_2m. Stimulus pushes the expected completion
// of each transfer into a scoreboard queue; a monitor pops and compares when a
// master sees waitrequest low. Cycle-level expectations (grant, mux, stalls)
// are checked inline. A second instance with ROUND_ROBIN=0 and no watchdog
// runs the contention pattern alongside the main one.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2m;

    typedef struct {
        logic        who;     // 0 = M0, 1 = M1
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        pulse;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] grant, grant2;
    logic       timeout_pulse, timeout_pulse2;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    exp_t mon_exp;
    logic mon_who;

    bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
    bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) n0_if ();
    bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) n1_if ();
    bus_arbiter_2m_if #(.ADDR_W(32), .DATA_W(32)) ns_if ();

    bus_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    bus_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) dut_fixed (
        .clk(clk), .rst(rst), .m0(n0_if), .m1(n1_if), .s(ns_if),
        .grant(grant2), .timeout_pulse(timeout_pulse2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic who, input logic [31:0] rdata, input logic [1:0] resp,
                        input logic pulse);
        exp_t e;
        e.who = who; e.rdata = rdata; e.resp = resp; e.pulse = pulse;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: a completion is any cycle where a master sees waitrequest low.
    always @(negedge clk) begin
        if (!rst && (!m0_if.waitrequest || !m1_if.waitrequest)) begin
            if (!m0_if.waitrequest && !m1_if.waitrequest) begin
                n_checks++; n_errors++;
                $display("FAIL both_complete: both waitrequests low at %0t", $time);
            end else begin
                mon_who = !m1_if.waitrequest;
                if (sb.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_completion: master %0d at %0t, expected none",
                             mon_who, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    check("sb_master", 32'(mon_who), 32'(mon_exp.who));
                    check("sb_readdata", mon_who ? m1_if.readdata : m0_if.readdata, mon_exp.rdata);
                    check("sb_response", 32'(mon_who ? m1_if.response : m0_if.response),
                          32'(mon_exp.resp));
                    check("sb_timeout_pulse", 32'(timeout_pulse), 32'(mon_exp.pulse));
                    check("sb_grant", 32'(grant), mon_exp.who ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        m0_if.addr = 32'h0000_0123; m0_if.read = 1'b1; m0_if.write = 1'b0;
        m0_if.writedata = 32'h0; m0_if.byteenable = 4'hF;
        m1_if.addr = 32'h0000_0456; m1_if.read = 1'b0; m1_if.write = 1'b1;
        m1_if.writedata = 32'h0; m1_if.byteenable = 4'hF;
        s_if.readdata = 32'hDEAD_BEEF; s_if.response = 2'b00; s_if.waitrequest = 1'b0;
        n0_if.addr = 32'h0; n0_if.read = 1'b0; n0_if.write = 1'b0;
        n0_if.writedata = 32'h0; n0_if.byteenable = 4'h0;
        n1_if.addr = 32'h0; n1_if.read = 1'b0; n1_if.write = 1'b0;
        n1_if.writedata = 32'h0; n1_if.byteenable = 4'h0;
        ns_if.readdata = 32'h0; ns_if.response = 2'b00; ns_if.waitrequest = 1'b0;

        // Reset state, with requests pending that must not leak through.
        step(); step();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_read", 32'(s_if.read), 32'd0);
        check("rst_s_write", 32'(s_if.write), 32'd0);
        check("rst_s_addr", s_if.addr, 32'd0);
        check("rst_s_writedata", s_if.writedata, 32'd0);
        check("rst_s_byteenable", 32'(s_if.byteenable), 32'd0);
        check("rst_m0_waitrequest", 32'(m0_if.waitrequest), 32'd1);
        check("rst_m1_waitrequest", 32'(m1_if.waitrequest), 32'd1);
        check("rst_m0_readdata", m0_if.readdata, 32'd0);
        check("rst_m1_response", 32'(m1_if.response), 32'd0);
        check("rst_timeout_pulse", 32'(timeout_pulse), 32'd0);

        step();
        rst = 1'b0; m0_if.read = 1'b0; m1_if.write = 1'b0;

        // 1: single M0 read, zero-wait slave.
        step();
        m0_if.read = 1'b1; m0_if.addr = 32'h0000_0010;
        s_if.waitrequest = 1'b0; s_if.readdata = 32'hCAFE_0001;
        @(negedge clk);
        check("t1_idle_grant", 32'(grant), 32'd0);
        check("t1_idle_wait", 32'(m0_if.waitrequest), 32'd1);
        step();
        push(1'b0, 32'hCAFE_0001, 2'b00, 1'b0);
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'd1);
        check("t1_s_read", 32'(s_if.read), 32'd1);
        check("t1_s_addr", s_if.addr, 32'h0000_0010);
        step();
        m0_if.read = 1'b0;
        @(negedge clk);
        check("t1_wait_after", 32'(m0_if.waitrequest), 32'd1);
        step();
        @(negedge clk);
        check("t1_back_idle", 32'(grant), 32'd0);

        // 2: contention, zero-wait; fresh reset so M0 wins first. The fixed-priority
        // instance gets the same pattern.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        step();
        m0_if.write = 1'b1; m0_if.addr = 32'h0000_0100; m0_if.writedata = 32'h1111_0000;
        m0_if.byteenable = 4'hF;
        m1_if.write = 1'b1; m1_if.addr = 32'h0000_0200; m1_if.writedata = 32'h2222_0000;
        m1_if.byteenable = 4'h3;
        s_if.waitrequest = 1'b0; s_if.readdata = 32'h5A5A_0000;
        n0_if.write = 1'b1; n0_if.byteenable = 4'hF;
        n1_if.write = 1'b1; n1_if.byteenable = 4'hF;
        @(negedge clk);
        check("t2_idle_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            push(1'(i % 2), 32'h5A5A_0000, 2'b00, 1'b0);
            @(negedge clk);
            check("t2_grant", 32'(grant), (i % 2 == 1) ? 32'd2 : 32'd1);
            check("t2_s_addr", s_if.addr, (i % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
            check("t2_s_writedata", s_if.writedata, (i % 2 == 1) ? 32'h2222_0000 : 32'h1111_0000);
            check("t2_s_byteenable", 32'(s_if.byteenable), (i % 2 == 1) ? 32'h3 : 32'hF);
            check("t2_fixed_grant", 32'(grant2), 32'd1);
            check("t2_fixed_m0_wait", 32'(n0_if.waitrequest), 32'd0);
            check("t2_fixed_m1_wait", 32'(n1_if.waitrequest), 32'd1);
            check("t2_fixed_pulse", 32'(timeout_pulse2), 32'd0);
        end
        step();
        m0_if.write = 1'b0; m1_if.write = 1'b0;
        n0_if.write = 1'b0; n1_if.write = 1'b0;
        @(negedge clk);
        check("t2_drop_wait", 32'(m0_if.waitrequest), 32'd1);
        step();
        @(negedge clk);
        check("t2_back_idle", 32'(grant), 32'd0);

        // 3: M1 write, slave stalls 3 cycles.
        step();
        m1_if.write = 1'b1; m1_if.addr = 32'h3000_0004; m1_if.writedata = 32'hA5A5_5A5A;
        m1_if.byteenable = 4'b0101;
        s_if.waitrequest = 1'b1; s_if.readdata = 32'h0000_3333;
        @(negedge clk);
        check("t3_idle_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            s_if.waitrequest = (i < 3);
            if (i == 3) push(1'b1, 32'h0000_3333, 2'b00, 1'b0);
            @(negedge clk);
            check("t3_s_write", 32'(s_if.write), 32'd1);
            check("t3_s_addr", s_if.addr, 32'h3000_0004);
            check("t3_s_writedata", s_if.writedata, 32'hA5A5_5A5A);
            check("t3_s_byteenable", 32'(s_if.byteenable), 32'b0101);
            check("t3_m1_wait", 32'(m1_if.waitrequest), (i < 3) ? 32'd1 : 32'd0);
            check("t3_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        end
        step();
        m1_if.write = 1'b0; s_if.waitrequest = 1'b0;
        @(negedge clk);
        check("t3_drop_wait", 32'(m1_if.waitrequest), 32'd1);
        step();

        // 4: watchdog (8 cycles) terminates a stuck M0 read, then pending M1 is served.
        step();
        m0_if.read = 1'b1; m0_if.addr = 32'h0000_0040;
        s_if.waitrequest = 1'b1; s_if.readdata = 32'hFFFF_FFFF; s_if.response = 2'b00;
        @(negedge clk);
        check("t4_idle_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 2) begin
                m1_if.read = 1'b1; m1_if.addr = 32'h0000_0080;
            end
            if (i == 7) push(1'b0, 32'h0, 2'b10, 1'b1);
            @(negedge clk);
            check("t4_grant", 32'(grant), 32'd1);
            check("t4_pulse", 32'(timeout_pulse), (i == 7) ? 32'd1 : 32'd0);
            check("t4_m0_wait", 32'(m0_if.waitrequest), (i == 7) ? 32'd0 : 32'd1);
            check("t4_m1_wait", 32'(m1_if.waitrequest), 32'd1);
        end
        step();
        m0_if.read = 1'b0;
        s_if.waitrequest = 1'b0; s_if.readdata = 32'h1234_5678;
        push(1'b1, 32'h1234_5678, 2'b00, 1'b0);
        @(negedge clk);
        check("t4_m1_grant", 32'(grant), 32'd2);
        check("t4_pulse_gone", 32'(timeout_pulse), 32'd0);
        step();
        m1_if.read = 1'b0;
        step();
        @(negedge clk);
        check("t4_back_idle", 32'(grant), 32'd0);

        // 6: slave acknowledges in the last watchdog cycle: normal completion wins.
        step();
        m0_if.write = 1'b1; m0_if.addr = 32'h0000_0060;
        s_if.waitrequest = 1'b1; s_if.readdata = 32'h600D_0006; s_if.response = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            step();
            s_if.waitrequest = (i < 7);
            if (i == 7) push(1'b0, 32'h600D_0006, 2'b00, 1'b0);
            @(negedge clk);
            check("t6_grant", 32'(grant), 32'd1);
            check("t6_pulse", 32'(timeout_pulse), 32'd0);
            check("t6_m0_wait", 32'(m0_if.waitrequest), (i < 7) ? 32'd1 : 32'd0);
        end
        step();
        m0_if.write = 1'b0; s_if.waitrequest = 1'b0;
        step();

        // 5: reset while M1 is stalled; afterwards contention goes to M0.
        step();
        m1_if.read = 1'b1; m1_if.addr = 32'h0000_0090; s_if.waitrequest = 1'b1;
        @(negedge clk);
        check("t5_idle_grant", 32'(grant), 32'd0);
        step();
        @(negedge clk);
        check("t5_granted", 32'(grant), 32'd2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_if.read = 1'b1; m0_if.addr = 32'h0000_00A0;
        s_if.waitrequest = 1'b0; s_if.readdata = 32'h7777_0000;
        @(negedge clk);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_s_read", 32'(s_if.read), 32'd0);
        check("t5_rst_m0_wait", 32'(m0_if.waitrequest), 32'd1);
        check("t5_rst_m1_wait", 32'(m1_if.waitrequest), 32'd1);
        step();
        push(1'b0, 32'h7777_0000, 2'b00, 1'b0);
        @(negedge clk);
        check("t5_first_grant", 32'(grant), 32'd1);
        check("t5_s_addr", s_if.addr, 32'h0000_00A0);
        step();
        m0_if.read = 1'b0;
        push(1'b1, 32'h7777_0000, 2'b00, 1'b0);
        @(negedge clk);
        check("t5_second_grant", 32'(grant), 32'd2);
        step();
        m1_if.read = 1'b0;
        step();
        @(negedge clk);
        check("t5_back_idle", 32'(grant), 32'd0);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
